rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Eight-requester round-robin arbiter that shares one single-owner resource (bus, ALU port, memory port) among eight clients in the CPU-on-FPGA design. Requests are level-sensitive. A winner keeps its grant until it drops its request or a hold timeout expires. Priority rotates past the last winner so no requester starves. Request detection uses an 8-way OR of the request lines.

## Interface
- MAX_HOLD, default 16: maximum consecutive grant cycles per tenure; 0 disables the timeout; legal range 0..255.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  level request per client; bit i belongs to client i.
- grant  output  8  one-hot grant, or all-zero; registered.
- grant_id  output  3  index of the current or most recent holder; registered.
- busy  output  1  high while any grant is asserted.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

## Operation
- States:
  - IDLE: grant = 0.
  - GRANT: exactly one grant bit is set.
- Reset values: state IDLE, grant 8'h00, grant_id 0, busy 0, timeout 0, hold counter 0, priority pointer last = 7. Client 0 therefore has first priority after reset.
- IDLE → GRANT when any req bit is high (8-way OR).
  - Winner is the first set bit in search order last+1, last+2, … last+8, all modulo 8. The search wraps from 7 to 0.
  - On the transition: grant ← onehot(winner), grant_id ← winner, last ← winner, hold counter ← 1.
- GRANT, holder's req still high, and either MAX_HOLD = 0 or counter < MAX_HOLD: stay in GRANT and increment the counter. The counter saturates at 255.
- GRANT → IDLE on release, when req[grant_id] = 0. Grant clears; timeout stays 0.
- GRANT → IDLE on timeout, when MAX_HOLD ≠ 0, counter = MAX_HOLD, and the holder's req is still high. Grant clears and timeout = 1 for exactly that cycle.
- Requests from non-holders never affect the current tenure.
- After revocation, the revoked client ranks lowest in the next arbitration because last equals its id. It can win again only if no other client requests.
- grant_id and last hold their values in IDLE.

## Timing
- Request to grant: req sampled high in IDLE at edge N gives grant high after edge N (1-cycle latency).
- Release to grant low: req[grant_id] low at edge M gives grant low after edge M.
- Next grant is issued no earlier than edge M+1. There is a mandatory one-cycle IDLE gap between tenures, and never two grant bits high.
- With MAX_HOLD = K, a holder that never releases sees grant high for exactly K cycles. timeout pulses in the cycle after the last grant cycle, coincident with the first IDLE cycle.
- A req pulse that rises and falls between edges is never seen. Clients must hold req until they observe grant.
- A client that drops req in the same cycle its grant first appears is treated as a normal release: one grant cycle, no timeout.
- reset high at any edge, including mid-tenure, forces all reset values at that edge and wins over every other condition. The first arbitration happens on the first edge with reset low.

## Structure
- Shared package:
  - N_REQ = 8 and ID_W = 3.
  - State encoding constants IDLE = 1'b0, GRANT = 1'b1.
  - HOLD_W = 8 (counter width).
- One natural sub-module: rr_pick8, purely combinational.
  - Inputs: req[7:0] and last[2:0].
  - Outputs: valid and winner[2:0].
  - Implementation: rotate right by last+1, find the lowest set bit, add the rotation back modulo 8.
- Top level holds the FSM, hold counter, pointer and output registers.
- The any-request term comes from an or8way instance; rr_pick8's valid must agree with it.

## Test plan
- Reset, then req = 8'h01 at edge 1 → grant = 8'h01 and grant_id = 0 after edge 1, busy = 1. Drop req → grant = 0 after the next edge.
- Fairness sweep: hold req = 8'hFF and let MAX_HOLD = 16 timeouts fire. Grants go 0,1,2,…,7,0 with a one-cycle gap each time, and each grant lasts exactly 16 cycles.
- Wrap-around: last = 6 after client 6 releases, then req = 8'h41 → client 0 wins, not 6. Next with req = 8'h41, after client 0 releases → client 6 wins.
- Timeout with MAX_HOLD = 4: client 3 holds req alone → grant lasts 4 cycles, timeout pulses for 1 cycle, client 3 is re-granted after the gap. Repeat with req = 8'h88 → client 7 wins before client 3.
- Reset mid-tenure: client 5 granted, reset high for 1 cycle → grant = 0, busy = 0, timeout = 0. With req = 8'h21 held, client 0 wins first after reset.
- Same-cycle release: client 2 drops req in the first grant cycle → exactly one grant cycle, timeout = 0. Continuous assertion check over all tests: grant is always one-hot or zero.

Source files
------------

// File: rtl/rr_arbiter8_pkg.sv
// Shared constants, state encoding and helpers for the eight-way round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int N_REQ  = 8;
  localparam int ID_W   = 3;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot8(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/or8way.sv
// Eight-input OR reduction used as the any-request detector.
module or8way (
  input  logic [7:0] in_i,
  output logic       out_o
);

  assign out_o = |in_i;

endmodule

// File: rtl/rr_arbiter8_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping 7 -> 0.
module rr_pick8
  import rr_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  last_i,
  output logic             valid_o,
  output logic [ID_W-1:0]  winner_o
);

  logic [ID_W-1:0]    shift;
  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [ID_W-1:0]    lowest;

  // Rotating right by last+1 puts the highest-priority client at bit 0.
  assign shift   = last_i + 3'd1;
  assign doubled = {req_i, req_i} >> shift;
  assign rotated = doubled[N_REQ-1:0];

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    lowest = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) lowest = ID_W'(i);
    end
  end

  assign valid_o  = |req_i;
  assign winner_o = lowest + shift;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with level requests and an optional hold timeout.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic             timeout
);

  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
  localparam bit                TIMEOUT_EN = (MAX_HOLD != 0);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [HOLD_W-1:0]  cnt_q, cnt_d;
  logic               timeout_q, timeout_d;

  logic               any_req;
  logic               pick_valid;
  logic [ID_W-1:0]    winner;

  or8way u_or8way (
    .in_i  (req),
    .out_o (any_req)
  );

  rr_pick8 u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .valid_o  (pick_valid),
    .winner_o (winner)
  );

  always_comb begin
    assert (pick_valid == any_req);
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = GRANT;
          grant_d    = onehot8(winner);
          grant_id_d = winner;
          last_d     = winner;
          cnt_d      = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (!req[grant_id_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (TIMEOUT_EN && (cnt_q == MAX_HOLD_C)) begin
          state_d   = IDLE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_q     <= ID_W'(N_REQ - 1);
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == GRANT);
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Randomised and directed bench for rr_arbiter8 (MAX_HOLD 16 and 4) against a behavioural model.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'h00;

  logic [7:0] g16, g4;
  logic [2:0] id16, id4;
  logic       busy16, busy4, to16, to4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(16)) dut16 (
    .clk(clk), .reset(reset), .req(req),
    .grant(g16), .grant_id(id16), .busy(busy16), .timeout(to16)
  );

  rr_arbiter8 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .reset(reset), .req(req),
    .grant(g4), .grant_id(id4), .busy(busy4), .timeout(to4)
  );

  typedef struct {
    int holder;  // -1 when nobody holds the resource
    int last;
    int gid;
    int cnt;
    bit to;
  } mdl_t;

  mdl_t m16 = '{holder: -1, last: 7, gid: 0, cnt: 0, to: 1'b0};
  mdl_t m4  = '{holder: -1, last: 7, gid: 0, cnt: 0, to: 1'b0};

  function automatic mdl_t step(input mdl_t m, input logic [7:0] r, input logic rst, input int mh);
    mdl_t n;
    n = m;
    if (rst) begin
      n = '{holder: -1, last: 7, gid: 0, cnt: 0, to: 1'b0};
      return n;
    end
    n.to = 1'b0;
    if (m.holder < 0) begin
      for (int k = 1; k <= 8; k++) begin
        int c;
        c = (m.last + k) % 8;
        if (n.holder < 0 && r[c]) begin
          n.holder = c;
          n.gid    = c;
          n.last   = c;
          n.cnt    = 1;
        end
      end
    end else if (!r[m.holder]) begin
      n.holder = -1;
    end else if (mh != 0 && m.cnt == mh) begin
      n.holder = -1;
      n.to     = 1'b1;
    end else begin
      n.cnt = (m.cnt < 255) ? m.cnt + 1 : 255;
    end
    return n;
  endfunction

  function automatic logic [7:0] exp_grant(input mdl_t m);
    logic [7:0] v;
    v = 8'h00;
    if (m.holder >= 0) v[m.holder] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m16 = step(m16, req, reset, 16);
    m4  = step(m4, req, reset, 4);
  end

  always @(negedge clk) begin
    check("m16_grant",   32'(g16),    32'(exp_grant(m16)));
    check("m16_id",      32'(id16),   32'(m16.gid));
    check("m16_busy",    32'(busy16), 32'(m16.holder >= 0));
    check("m16_timeout", 32'(to16),   32'(m16.to));
    check("m4_grant",    32'(g4),     32'(exp_grant(m4)));
    check("m4_id",       32'(id4),    32'(m4.gid));
    check("m4_busy",     32'(busy4),  32'(m4.holder >= 0));
    check("m4_timeout",  32'(to4),    32'(m4.to));
    check("onehot16",    32'($onehot0(g16)), 32'(1));
    check("onehot4",     32'($onehot0(g4)),  32'(1));
  end

  function automatic logic [7:0] gnt(input int sel);
    return (sel != 0) ? g4 : g16;
  endfunction

  function automatic int gid(input int sel);
    return (sel != 0) ? int'(id4) : int'(id16);
  endfunction

  task automatic wait_grant(input int sel, input int budget, output int id);
    id = -1;
    for (int i = 0; i < budget; i++) begin
      if (gnt(sel) != 8'h00) begin
        id = gid(sel);
        return;
      end
      @(negedge clk);
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_grant: no grant on dut %0d within %0d cycles", sel, budget);
  endtask

  task automatic tenure_len(input int sel, input int budget, output int len);
    len = 0;
    while (gnt(sel) != 8'h00 && len < budget) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    req   = 8'h00;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int id, len;
    @(negedge clk);
    check("rst_grant", 32'(g16), 32'h00);
    check("rst_id",    32'(id16), 32'd0);
    check("rst_busy",  32'(busy16), 32'd0);
    reset = 1'b0;

    // Basic grant and release.
    req = 8'h01;
    @(negedge clk);
    check("basic_grant", 32'(g16), 32'h01);
    check("basic_id",    32'(id16), 32'd0);
    check("basic_busy",  32'(busy16), 32'd1);
    req = 8'h00;
    @(negedge clk);
    check("basic_release", 32'(g16), 32'h00);

    // Fairness sweep with all requesters on.
    do_reset();
    req = 8'hFF;
    wait_grant(0, 4, id);
    for (int c = 0; c <= 8; c++) begin
      check("sweep_id", 32'(id), 32'(c % 8));
      tenure_len(0, 40, len);
      check("sweep_len", 32'(len), 32'd16);
      check("sweep_timeout", 32'(to16), 32'd1);
      @(negedge clk);
      check("sweep_gap", 32'(g16 != 8'h00), 32'd1);
      id = int'(id16);
    end

    // Wrap-around of the priority pointer.
    do_reset();
    req = 8'h40;
    wait_grant(0, 4, id);
    check("wrap_first", 32'(id), 32'd6);
    req = 8'h00;
    @(negedge clk);
    check("wrap_idle", 32'(g16), 32'h00);
    req = 8'h41;
    @(negedge clk);
    check("wrap_zero_wins", 32'(g16), 32'h01);
    req = 8'h40;
    @(negedge clk);
    check("wrap_gap", 32'(g16), 32'h00);
    @(negedge clk);
    check("wrap_six_wins", 32'(g16), 32'h40);

    // Timeout with MAX_HOLD = 4.
    do_reset();
    req = 8'h08;
    wait_grant(1, 4, id);
    check("to4_id", 32'(id), 32'd3);
    tenure_len(1, 20, len);
    check("to4_len", 32'(len), 32'd4);
    check("to4_pulse", 32'(to4), 32'd1);
    @(negedge clk);
    check("to4_regrant", 32'(g4), 32'h08);
    check("to4_pulse_end", 32'(to4), 32'd0);
    req = 8'h88;
    tenure_len(1, 20, len);
    check("to4_len2", 32'(len), 32'd4);
    check("to4_pulse2", 32'(to4), 32'd1);
    @(negedge clk);
    check("to4_seven_wins", 32'(g4), 32'h80);

    // Reset in the middle of a tenure.
    do_reset();
    req = 8'h20;
    wait_grant(0, 4, id);
    check("midrst_id", 32'(id), 32'd5);
    @(negedge clk);
    req   = 8'h21;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_grant",   32'(g16), 32'h00);
    check("midrst_busy",    32'(busy16), 32'd0);
    check("midrst_timeout", 32'(to16), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_zero_first", 32'(g16), 32'h01);

    // Release in the first grant cycle.
    do_reset();
    req = 8'h04;
    wait_grant(0, 4, id);
    check("same_id", 32'(id), 32'd2);
    req = 8'h00;
    @(negedge clk);
    check("same_grant", 32'(g16), 32'h00);
    check("same_timeout", 32'(to16), 32'd0);
    check("same_timeout4", 32'(to4), 32'd0);

    // Randomised traffic, checked every cycle by the model comparison.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      else if ($urandom_range(0, 5) == 0) req = req & ~g16;
      else if ($urandom_range(0, 9) == 0) req = 8'h00;
      @(negedge clk);
    end
    reset = 1'b0;
    req   = 8'h00;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
